// File: rtl/audio_sched_if.sv
// rtl/audio_sched_if.sv - request/sample bundle between audio sources and the DAC scheduler
interface audio_sched_if;
  logic [2:0] req;
  logic [5:0] d0;
  logic [5:0] d1;
  logic [5:0] d2;
  logic       mute;
  logic [2:0] gnt;
  logic [5:0] q;
  logic       busy;

  modport master (output req, d0, d1, d2, mute, input gnt, q, busy);
  modport slave  (input req, d0, d1, d2, mute, output gnt, q, busy);
endinterface

// File: rtl/audio_sched.sv
// rtl/audio_sched.sv - round-robin arbiter feeding one held 6-bit sample to a sigma-delta DAC
module audio_sched #(
  parameter int unsigned HOLD = 8
) (
  input  logic          clk,
  input  logic          rst,
  audio_sched_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] gnt_q, gnt_d;
  logic [5:0] q_q, q_d;

  logic [1:0] c0, c1, c2;
  logic [1:0] win;
  logic [5:0] d_sel;

  function automatic logic [1:0] nxt(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // Rotation starts just after the last winner; earliest candidate in the order wins.
  always_comb begin
    c0  = nxt(last_q);
    c1  = nxt(c0);
    c2  = nxt(c1);
    win = c2;
    if (bus.req[c1]) win = c1;
    if (bus.req[c0]) win = c0;
  end

  always_comb begin
    case (sel_q)
      2'd0:    d_sel = bus.d0;
      2'd1:    d_sel = bus.d1;
      default: d_sel = bus.d2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = 3'b000;
    q_d     = q_q;
    case (state_q)
      S_IDLE: begin
        if (|bus.req) begin
          sel_d   = win;
          last_d  = win;
          gnt_d   = 3'b001 << win;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        q_d     = d_sel;
        cnt_d   = 8'(HOLD - 1);
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) state_d = S_IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
    // Mute overrides the sample only; arbitration and timing carry on untouched.
    if (bus.mute) q_d = 6'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd2;
      cnt_q   <= 8'd0;
      gnt_q   <= 3'b000;
      q_q     <= 6'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      q_q     <= q_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.q    = q_q;
  assign bus.busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_audio_sched.sv
// tb/tb_audio_sched.sv - directed bench with a cycle model for audio_sched
module tb_audio_sched;
  localparam int HOLD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail  = 0;

  audio_sched_if aif ();
  audio_sched_if aif1 ();

  audio_sched #(.HOLD(HOLD)) dut  (.clk(clk), .rst(rst), .bus(aif.slave));
  audio_sched #(.HOLD(1))    dut1 (.clk(clk), .rst(rst), .bus(aif1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a busy window of HOLD+1 cycles follows each grant; data is taken on the first edge of that window.
  int         m_left;
  int         m_win;
  int         m_last;
  logic [2:0] m_gnt;
  logic [5:0] m_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_last = 2; m_win = 0; m_gnt = 3'b000; m_q = 6'd0;
    end else begin
      if (m_left == 0) begin
        m_gnt = 3'b000;
        for (int k = 1; k <= 3; k++) begin
          int s;
          s = (m_last + k) % 3;
          if (aif.req[s] && m_gnt == 3'b000) begin
            m_gnt = 3'(1 << s);
            m_win = s;
          end
        end
        if (m_gnt != 3'b000) begin
          m_last = m_win;
          m_left = HOLD + 1;
        end
      end else begin
        if (m_left == HOLD + 1)
          m_q = (m_win == 0) ? aif.d0 : (m_win == 1) ? aif.d1 : aif.d2;
        m_gnt = 3'b000;
        m_left--;
      end
      if (aif.mute) m_q = 6'd0;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_gnt",  int'(aif.gnt),  int'(m_gnt));
    chk("model_q",    int'(aif.q),    int'(m_q));
    chk("model_busy", int'(aif.busy), int'(m_left != 0));
    chk("gnt_onehot", int'($countones(aif.gnt) <= 1), 1);
  end

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int bound, output logic [2:0] g, output int n);
    n = 0;
    g = 3'b000;
    while (g == 3'b000 && n < bound) begin
      sample();
      n++;
      g = aif.gnt;
    end
    chk("wait_gnt_timeout", int'(g != 3'b000), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [2:0] g;
    int         n, c, ng, pend, nb, lastg, nbl;
    logic [2:0] gv[4];
    int         tc[4];
    logic [5:0] qv[4];
    logic [2:0] exp_g[4];
    logic [5:0] exp_q[4];

    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_q = '{6'd1, 6'd2, 6'd3, 6'd1};
    aif.req = 3'b000; aif.d0 = 6'd0; aif.d1 = 6'd0; aif.d2 = 6'd0; aif.mute = 1'b0;
    aif1.req = 3'b000; aif1.d0 = 6'd5; aif1.d1 = 6'd0; aif1.d2 = 6'd0; aif1.mute = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_q", int'(aif.q), 0);
    chk("reset_gnt", int'(aif.gnt), 0);
    chk("reset_busy", int'(aif.busy), 0);
    rst = 1'b0;

    // Single request from source 1
    @(negedge clk);
    aif.d1 = 6'h2A; aif.req = 3'b010;
    sample();
    chk("t1_gnt", int'(aif.gnt), 3'b010);
    chk("t1_busy", int'(aif.busy), 1);
    @(negedge clk);
    aif.req = 3'b000;
    sample();
    chk("t1_q", int'(aif.q), 6'h2A);
    chk("t1_gnt_drop", int'(aif.gnt), 0);
    c = 2;
    nb = 0;
    while (aif.busy && nb < 30) begin
      sample();
      nb++;
      if (aif.busy) c++;
    end
    chk("t1_busy_len", c, HOLD + 1);
    chk("t1_q_hold", int'(aif.q), 6'h2A);

    // Full rotation with all sources requesting
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t2_rst_busy", int'(aif.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    aif.d0 = 6'd1; aif.d1 = 6'd2; aif.d2 = 6'd3; aif.req = 3'b111;
    ng = 0; pend = 0;
    for (int cyc = 0; cyc < 60 && (ng < 4 || pend != 0); cyc++) begin
      sample();
      if (pend != 0) begin
        qv[ng-1] = aif.q;
        pend = 0;
      end
      if (aif.gnt != 3'b000 && ng < 4) begin
        gv[ng] = aif.gnt;
        tc[ng] = cyc;
        ng++;
        pend = 1;
      end
    end
    chk("t2_grant_count", ng, 4);
    for (int i = 0; i < ng; i++) begin
      chk($sformatf("t2_gnt%0d", i), int'(gv[i]), int'(exp_g[i]));
      chk($sformatf("t2_q%0d", i), int'(qv[i]), int'(exp_q[i]));
      if (i > 0) chk($sformatf("t2_space%0d", i), tc[i] - tc[i-1], HOLD + 2);
    end

    // Mute pulse during HOLD
    @(negedge clk);
    aif.req = 3'b001; aif.d0 = 6'h3F;
    wait_gnt(30, g, n);
    chk("t3_gnt", int'(g), 3'b001);
    sample();
    chk("t3_q_load", int'(aif.q), 6'h3F);
    @(negedge clk);
    aif.mute = 1'b1;
    sample();
    chk("t3_q_muted", int'(aif.q), 0);
    @(negedge clk);
    aif.mute = 1'b0;
    sample();
    chk("t3_q_stays0", int'(aif.q), 0);
    wait_gnt(30, g, n);
    chk("t3_space", n + 3, HOLD + 2);
    chk("t3_q_at_gnt", int'(aif.q), 0);
    sample();
    chk("t3_q_reload", int'(aif.q), 6'h3F);

    // Reset during source 1 HOLD
    @(negedge clk);
    aif.req = 3'b010; aif.d1 = 6'h15;
    wait_gnt(30, g, n);
    chk("t4_gnt", int'(g), 3'b010);
    repeat (3) sample();
    @(negedge clk);
    rst = 1'b1; aif.req = 3'b011; aif.d0 = 6'h07;
    #1;
    chk("t4_rst_gnt", int'(aif.gnt), 0);
    chk("t4_rst_q", int'(aif.q), 0);
    chk("t4_rst_busy", int'(aif.busy), 0);
    @(negedge clk);
    rst = 1'b0;
    sample();
    chk("t4_first_gnt", int'(aif.gnt), 3'b001);
    @(negedge clk);
    aif.req = 3'b000;
    sample();
    chk("t4_q", int'(aif.q), 6'h07);

    // One-cycle request pulse while busy
    @(negedge clk);
    @(negedge clk);
    aif.req = 3'b100; aif.d2 = 6'h31;
    @(negedge clk);
    aif.req = 3'b000;
    c = 0;
    repeat (20) begin
      sample();
      if (aif.gnt != 3'b000) c++;
    end
    chk("t5_no_grant", c, 0);
    chk("t5_q_unchanged", int'(aif.q), 6'h07);
    chk("t5_idle", int'(aif.busy), 0);

    // HOLD=1 instance: grant every 3 cycles, one idle cycle per period
    @(negedge clk);
    aif1.req = 3'b001;
    n = 0;
    while (aif1.gnt == 3'b000 && n < 10) begin
      sample();
      n++;
    end
    chk("h1_first_gnt", int'(aif1.gnt), 3'b001);
    ng = 1; lastg = 0; nbl = 0;
    for (int i = 1; i < 12; i++) begin
      sample();
      if (aif1.gnt != 3'b000) begin
        chk("h1_gap", i - lastg, 3);
        lastg = i;
        ng++;
      end
      if (!aif1.busy) nbl++;
    end
    chk("h1_grants", ng, 4);
    chk("h1_busy_low", nbl, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
